// File: rtl/cw_sample_reader.sv
`default_nettype none
// ============================================================================
// Module   : cw_sample_reader
// Brief    : Tracks capture-buffer fill level and streams the window oldest-first.
// Revision : 1.0
// ============================================================================
module cw_sample_reader #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 89
) (
   input  logic              trig_clk,
   input  logic              jrstn,
   input  logic              wt_ce,
   input  logic              wt_en,
   input  logic [ADDR_W-1:0] wt_addr,
   input  logic              rd_start,
   input  logic              rd_abort,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              s_valid,
   input  logic              s_ready,
   output logic [DATA_W-1:0] s_data,
   output logic [ADDR_W:0]   s_index,
   output logic              s_last,
   output logic [ADDR_W:0]   sample_cnt,
   output logic              busy,
   output logic              done,
   output logic              overrun
);
   localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   C_DEPTH     = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] C_ONE_A     = ADDR_W'(1);
   localparam logic [ADDR_W:0]   C_ONE_C     = (ADDR_W + 1)'(1);
   localparam int                C_ENT_W     = DATA_W + ADDR_W + 2;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_DONE = 2'd2} state_t;

   state_t               r_state, w_state_nx;
   logic                 r_ce_d, r_has_data, r_wrapped, r_overrun;
   logic [ADDR_W-1:0]    r_last_addr, r_rd_addr;
   logic [ADDR_W:0]      r_sample_cnt, r_count, r_issued, r_push_idx;
   logic                 r_inflight, r_v0, r_v1;
   logic [C_ENT_W-1:0]   r_h, r_t;

   logic                 w_ce_rise, w_wr, w_has_nx, w_wrap_nx;
   logic [ADDR_W-1:0]    w_last_nx, w_start;
   logic [ADDR_W:0]      w_cnt_nx;
   logic                 w_pop, w_push, w_abort, w_accept, w_issue, w_new_last;
   logic [1:0]           w_occ;
   logic [C_ENT_W-1:0]   w_new;

   assign w_ce_rise = wt_ce & ~r_ce_d;
   assign w_wr      = wt_ce & wt_en;

   // Next tracker values feed sample_cnt so it is ready the cycle after a write.
   always_comb begin
      w_has_nx  = r_has_data & ~w_ce_rise;
      w_wrap_nx = r_wrapped & ~w_ce_rise;
      w_last_nx = r_last_addr;
      if (w_wr) begin
         w_has_nx  = 1'b1;
         w_last_nx = wt_addr;
         if (wt_addr == C_LAST_ADDR) begin
            w_wrap_nx = 1'b1;
         end
      end
      if (!w_has_nx) begin
         w_cnt_nx = '0;
      end else if (w_wrap_nx) begin
         w_cnt_nx = C_DEPTH;
      end else begin
         w_cnt_nx = {1'b0, w_last_nx} + C_ONE_C;
      end
   end

   always_ff @(posedge trig_clk) begin
      if (!jrstn) begin
         r_ce_d       <= 1'b0;
         r_has_data   <= 1'b0;
         r_wrapped    <= 1'b0;
         r_last_addr  <= '0;
         r_sample_cnt <= '0;
      end else begin
         r_ce_d       <= wt_ce;
         r_has_data   <= w_has_nx;
         r_wrapped    <= w_wrap_nx;
         r_last_addr  <= w_last_nx;
         r_sample_cnt <= w_cnt_nx;
      end
   end

   assign w_start  = (r_wrapped && (r_last_addr != C_LAST_ADDR)) ? (r_last_addr + C_ONE_A) : '0;
   assign w_accept = (r_state == S_IDLE) & rd_start & ~wt_ce;
   assign w_abort  = rd_abort | w_ce_rise;
   assign w_pop    = r_v0 & s_ready;
   assign w_push   = r_inflight;
   // Outstanding words after this cycle's pop; keeps the 2-entry skid from overflowing.
   assign w_occ    = {1'b0, r_v0} + {1'b0, r_v1} + {1'b0, r_inflight} - {1'b0, w_pop};
   assign w_issue  = (r_state == S_READ) & ~w_abort & (r_issued < r_count) & (w_occ < 2'd2);
   assign w_new_last = (r_push_idx == (r_count - C_ONE_C));
   assign w_new    = {w_new_last, r_push_idx, ram_rd_data};

   always_ff @(posedge trig_clk) begin
      if (!jrstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nx = (r_sample_cnt == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (w_abort) begin
               w_state_nx = S_IDLE;
            end else if (w_pop && r_h[C_ENT_W-1]) begin
               w_state_nx = S_DONE;
            end
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge trig_clk) begin
      if (!jrstn) begin
         r_count    <= '0;
         r_issued   <= '0;
         r_rd_addr  <= '0;
         r_push_idx <= '0;
         r_inflight <= 1'b0;
         r_overrun  <= 1'b0;
         r_v0       <= 1'b0;
         r_v1       <= 1'b0;
         r_h        <= '0;
         r_t        <= '0;
      end else begin
         if (w_accept) begin
            r_count    <= r_sample_cnt;
            r_issued   <= '0;
            r_rd_addr  <= w_start;
            r_push_idx <= '0;
            r_overrun  <= 1'b0;
         end
         if ((r_state != S_IDLE) && w_ce_rise) begin
            r_overrun <= 1'b1;
         end
         if ((r_state == S_READ) && w_abort) begin
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_inflight <= 1'b0;
         end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
               r_issued  <= r_issued + C_ONE_C;
               r_rd_addr <= (r_rd_addr == C_LAST_ADDR) ? '0 : (r_rd_addr + C_ONE_A);
            end
            if (w_push) begin
               r_push_idx <= r_push_idx + C_ONE_C;
            end
            case ({w_pop, w_push})
               2'b11: begin
                  if (r_v1) begin
                     r_h <= r_t;
                     r_t <= w_new;
                  end else begin
                     r_h <= w_new;
                  end
               end
               2'b10: begin
                  if (r_v1) begin
                     r_h  <= r_t;
                     r_v1 <= 1'b0;
                  end else begin
                     r_v0 <= 1'b0;
                  end
               end
               2'b01: begin
                  if (!r_v0) begin
                     r_h  <= w_new;
                     r_v0 <= 1'b1;
                  end else begin
                     r_t  <= w_new;
                     r_v1 <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ram_rd_en   = w_issue;
   assign ram_rd_addr = r_rd_addr;
   assign s_valid     = r_v0;
   assign s_data      = r_h[DATA_W-1:0];
   assign s_index     = r_h[DATA_W +: (ADDR_W + 1)];
   assign s_last      = r_h[C_ENT_W-1];
   assign sample_cnt  = r_sample_cnt;
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign overrun     = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_cw_sample_reader.sv
`default_nettype none
// Directed bench for cw_sample_reader with a behavioural sample RAM (DEPTH=16).
module tb_cw_sample_reader;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int DATA_W = 8;

   logic              trig_clk = 1'b0;
   logic              jrstn    = 1'b0;
   logic              wt_ce    = 1'b0;
   logic              wt_en    = 1'b0;
   logic [ADDR_W-1:0] wt_addr  = '0;
   logic              rd_start = 1'b0;
   logic              rd_abort = 1'b0;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data = '0;
   logic              s_valid;
   logic              s_ready  = 1'b0;
   logic [DATA_W-1:0] s_data;
   logic [ADDR_W:0]   s_index;
   logic              s_last;
   logic [ADDR_W:0]   sample_cnt;
   logic              busy, done, overrun;

   logic [DATA_W-1:0] wdata = '0;
   logic [DATA_W-1:0] mem      [DEPTH];
   logic [DATA_W-1:0] exp_data [DEPTH];
   logic [ADDR_W-1:0] exp_addr [DEPTH];
   logic [27:0]       all_outs;
   logic [6:0]        pat = 7'b1101001;
   int checks = 0;
   int errors = 0;

   assign all_outs = {ram_rd_en, ram_rd_addr, s_valid, s_data, s_index, s_last,
                      sample_cnt, busy, done, overrun};

   cw_sample_reader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .trig_clk(trig_clk), .jrstn(jrstn), .wt_ce(wt_ce), .wt_en(wt_en), .wt_addr(wt_addr),
      .rd_start(rd_start), .rd_abort(rd_abort), .ram_rd_en(ram_rd_en),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .s_valid(s_valid),
      .s_ready(s_ready), .s_data(s_data), .s_index(s_index), .s_last(s_last),
      .sample_cnt(sample_cnt), .busy(busy), .done(done), .overrun(overrun));

   always #5 trig_clk = ~trig_clk;

   always @(posedge trig_clk) begin
      if (wt_ce && wt_en) mem[wt_addr] <= wdata;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge trig_clk);
      #1;
   endtask

   task automatic wr(input int a0, input int a1, input logic [7:0] base);
      for (int a = a0; a <= a1; a++) begin
         wt_en   = 1'b1;
         wt_addr = ADDR_W'(a);
         wdata   = base + 8'(a);
         tick();
      end
      wt_en = 1'b0;
   endtask

   task automatic capture_small();
      wt_ce = 1'b1;
      wr(0, 4, 8'hA0);
      wt_ce = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         exp_addr[i] = ADDR_W'(i);
         exp_data[i] = 8'hA0 + 8'(i);
      end
   endtask

   task automatic do_read(input string tag, input int n, input bit bp);
      int got = 0;
      int issued = 0;
      int maxout = 0;
      int c = 0;
      bit stall = 0;
      bit first = 1;
      logic [DATA_W-1:0] hd = '0;
      logic [ADDR_W:0]   hi = '0;
      rd_start = 1'b1;
      s_ready  = 1'b1;
      tick();
      rd_start = 1'b0;
      while (got < n && c < 80) begin
         c++;
         if (bp) s_ready = (c >= 3 && c < 10) ? pat[c-3] : 1'b1;
         #1;
         if (ram_rd_en) begin
            if (issued < DEPTH) check({tag, "_rd_addr"}, 32'(ram_rd_addr), 32'(exp_addr[issued]));
            issued++;
         end
         if (stall) check({tag, "_hold"}, {s_valid, s_index, s_data}, {1'b1, hi, hd});
         if (s_valid) begin
            if (first && !bp) check({tag, "_latency"}, c, 3);
            first = 0;
            if (s_ready) begin
               check({tag, "_sample"}, {s_index, s_data, s_last},
                     {5'(got), exp_data[got], (got == n - 1)});
               got++;
            end
            stall = !s_ready;
            hd = s_data;
            hi = s_index;
         end else begin
            stall = 0;
         end
         if (issued - got > maxout) maxout = issued - got;
         if (got < n) begin
            @(posedge trig_clk);
            #1;
         end
      end
      check({tag, "_count"}, got, n);
      check({tag, "_issued"}, issued, n);
      check({tag, "_max_outstanding_le2"}, 32'(maxout <= 2), 1);
      tick();
      check({tag, "_done_pulse"}, {s_valid, busy, done}, 3'b011);
      tick();
      check({tag, "_idle_after"}, {s_valid, busy, done}, 3'b000);
   endtask

   initial begin
      int got;
      bit bad;
      // Reset state
      tick();
      tick();
      check("reset_outputs", 32'(all_outs), 0);
      jrstn = 1'b1;
      tick();

      // Empty buffer: immediate done, no data
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("empty_done", {s_valid, busy, done, ram_rd_en}, 4'b0110);
      tick();
      check("empty_idle", {s_valid, busy, done}, 3'b000);

      // Request while capture window is open is ignored
      wt_ce = 1'b1;
      tick();
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("ignored_busy0", {busy, done}, 2'b00);
      tick();
      check("ignored_busy1", {busy, done}, 2'b00);
      wt_ce = 1'b0;
      tick();

      // No-wrap readback
      capture_small();
      check("nowrap_cnt", 32'(sample_cnt), 5);
      do_read("nowrap", 5, 1'b0);

      // Wrapped buffer: oldest is addr 6
      wt_ce = 1'b1;
      wr(0, 15, 8'hA0);
      wr(0, 5, 8'hB0);
      wt_ce = 1'b0;
      tick();
      tick();
      check("wrap_cnt", 32'(sample_cnt), 16);
      for (int i = 0; i < 16; i++) begin
         exp_addr[i] = ADDR_W'((6 + i) % 16);
         exp_data[i] = (i < 10) ? (8'hA6 + 8'(i)) : (8'hB0 + 8'(i - 10));
      end
      do_read("wrap", 16, 1'b0);

      // Backpressure
      capture_small();
      check("bp_cnt", 32'(sample_cnt), 5);
      do_read("bp", 5, 1'b1);

      // Abort after second accepted sample
      rd_start = 1'b1;
      s_ready  = 1'b1;
      tick();
      rd_start = 1'b0;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         if (s_valid && s_ready) got++;
         if (got == 2) break;
         tick();
      end
      check("abort_two_accepted", got, 2);
      tick();
      rd_abort = 1'b1;
      tick();
      rd_abort = 1'b0;
      check("abort_stop", {s_valid, busy, done}, 3'b000);
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (done || s_valid || busy) bad = 1;
      end
      check("abort_no_done", 32'(bad), 0);

      // Capture restart during readback -> overrun
      s_ready  = 1'b0;
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      tick();
      tick();
      check("ovr_busy_before", {busy, overrun}, 2'b10);
      wt_ce = 1'b1;
      tick();
      check("ovr_stopped", {s_valid, busy, done, overrun}, 4'b0001);
      wt_ce = 1'b0;
      tick();
      tick();
      check("ovr_sticky", {overrun, sample_cnt}, {1'b1, 5'd0});
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("ovr_cleared", {overrun, done}, 2'b01);
      tick();

      // Reset in the middle of a readback
      capture_small();
      s_ready  = 1'b1;
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      tick();
      tick();
      check("midrst_streaming", {s_valid, busy}, 2'b11);
      jrstn = 1'b0;
      tick();
      check("midrst_outputs", 32'(all_outs), 0);
      jrstn = 1'b1;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (all_outs != '0) bad = 1;
      end
      check("midrst_quiet", 32'(bad), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
